tile_core_l15_bridge: RTL and testbench

TILE_CORE_L15_BRIDGE -- requirements
Module: tile_core_l15_bridge

---
 rtl/tile_core_l15_bridge.sv | 161 ++++++++++++++++
 tb/tb_tile_core_l15_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_core_l15_bridge.sv
// tile_core_l15_bridge
//   Bridges a simple valid/ready core memory port to the OpenPiton L1.5
//   transducer interface. One request is outstanding at a time:
//   IDLE -> REQ (val held until header_ack) -> WAIT (for LOAD_RET/ST_ACK)
//   -> RESP (mem_ready pulse) -> IDLE.
//
//   Build option: define TILE_CORE_L15_BSWAP_EN to byte-reverse store and
//   load-return data within each 32-bit word (big-endian L1.5 side).
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     mem_*                     core side: valid/addr/wdata/wstrb in,
//                               ready pulse and rdata out
//     transducer_l15_*          request to L1.5 (val/rqtype/size/address/
//                               data/nc, remaining controls tied to 0),
//                               plus req_ack for consuming responses
//     l15_transducer_*          header_ack, response val/returntype/data_0
module tile_core_l15_bridge #(
   parameter int PHY_ADDR_WIDTH   = 40,
   parameter int NC_ADDR_BIT      = 31,
   parameter int L15_AMO_OP_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_valid,
   input  logic [31:0]                 mem_addr,
   input  logic [31:0]                 mem_wdata,
   input  logic [3:0]                  mem_wstrb,
   output logic                        mem_ready,
   output logic [31:0]                 mem_rdata,
   output logic                        transducer_l15_val,
   output logic [4:0]                  transducer_l15_rqtype,
   output logic [2:0]                  transducer_l15_size,
   output logic [PHY_ADDR_WIDTH-1:0]   transducer_l15_address,
   output logic [63:0]                 transducer_l15_data,
   output logic                        transducer_l15_nc,
   output logic [L15_AMO_OP_WIDTH-1:0] transducer_l15_amo_op,
   output logic                        transducer_l15_threadid,
   output logic                        transducer_l15_prefetch,
   output logic                        transducer_l15_invalidate_cacheline,
   output logic                        transducer_l15_blockstore,
   output logic                        transducer_l15_blockinitstore,
   output logic [1:0]                  transducer_l15_l1rplway,
   output logic [63:0]                 transducer_l15_data_next_entry,
   output logic [32:0]                 transducer_l15_csm_data,
   input  logic                        l15_transducer_header_ack,
   input  logic                        l15_transducer_val,
   input  logic [3:0]                  l15_transducer_returntype,
   input  logic [63:0]                 l15_transducer_data_0,
   output logic                        transducer_l15_req_ack
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [4:0] RQ_LOAD  = 5'b00000;
   localparam logic [4:0] RQ_STORE = 5'b00001;
   localparam logic [3:0] RT_LOAD  = 4'b0000;
   localparam logic [3:0] RT_STACK = 4'b0100;

   state_t                      state;
   logic [4:0]                  rqtype;
   logic [2:0]                  size;
   logic [PHY_ADDR_WIDTH-1:0]   address;
   logic                        nc;
   logic [31:0]                 wword;

   logic [2:0]                  size_next;
   logic [1:0]                  low_next;
   logic                        resp_hit;
   logic [31:0]                 ret_word;

   function automatic logic [31:0] lane(input logic [31:0] w);
`ifdef TILE_CORE_L15_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // Narrow stores only for the exact byte / aligned-halfword patterns;
   // everything else (loads, full word, sparse masks) goes out as a word.
   always_comb begin
      size_next = 3'b010;
      low_next  = 2'b00;
      case (mem_wstrb)
         4'b0001: begin size_next = 3'b000; low_next = 2'b00; end
         4'b0010: begin size_next = 3'b000; low_next = 2'b01; end
         4'b0100: begin size_next = 3'b000; low_next = 2'b10; end
         4'b1000: begin size_next = 3'b000; low_next = 2'b11; end
         4'b0011: begin size_next = 3'b001; low_next = 2'b00; end
         4'b1100: begin size_next = 3'b001; low_next = 2'b10; end
         default: begin size_next = 3'b010; low_next = 2'b00; end
      endcase
   end

   assign resp_hit = l15_transducer_val &&
                     (l15_transducer_returntype == RT_LOAD ||
                      l15_transducer_returntype == RT_STACK);

   // Address bit 2 clear selects the upper half of the returned doubleword.
   assign ret_word = address[2] ? l15_transducer_data_0[31:0]
                                : l15_transducer_data_0[63:32];

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         transducer_l15_val <= 1'b0;
         mem_ready          <= 1'b0;
         mem_rdata          <= '0;
         rqtype             <= '0;
         size               <= '0;
         address            <= '0;
         nc                 <= 1'b0;
         wword              <= '0;
      end else begin
         case (state)
            IDLE: if (mem_valid) begin
               rqtype             <= (mem_wstrb == 4'b0000) ? RQ_LOAD : RQ_STORE;
               size               <= size_next;
               address            <= PHY_ADDR_WIDTH'({mem_addr[31:2], low_next});
               nc                 <= mem_addr[NC_ADDR_BIT];
               wword              <= lane(mem_wdata);
               transducer_l15_val <= 1'b1;
               state              <= REQ;
            end
            // A response landing with header_ack is dropped (acked only).
            REQ: if (l15_transducer_header_ack) begin
               transducer_l15_val <= 1'b0;
               state              <= WAIT;
            end
            WAIT: if (resp_hit) begin
               mem_ready <= 1'b1;
               mem_rdata <= (rqtype == RQ_LOAD) ? lane(ret_word) : 32'h0;
               state     <= RESP;
            end
            RESP: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign transducer_l15_rqtype               = rqtype;
   assign transducer_l15_size                 = size;
   assign transducer_l15_address              = address;
   assign transducer_l15_nc                   = nc;
   assign transducer_l15_data                 = {wword, wword};
   assign transducer_l15_req_ack              = l15_transducer_val;
   assign transducer_l15_amo_op               = '0;
   assign transducer_l15_threadid             = 1'b0;
   assign transducer_l15_prefetch             = 1'b0;
   assign transducer_l15_invalidate_cacheline = 1'b0;
   assign transducer_l15_blockstore           = 1'b0;
   assign transducer_l15_blockinitstore       = 1'b0;
   assign transducer_l15_l1rplway             = 2'b00;
   assign transducer_l15_data_next_entry      = 64'h0;
   assign transducer_l15_csm_data             = 33'h0;

endmodule

// File: tb/tb_tile_core_l15_bridge.sv
// Directed bench for tile_core_l15_bridge: loads, byte/half/word stores,
// withheld header_ack, invalidation in WAIT, stray responses, reset in WAIT.
module tb_tile_core_l15_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        l15_val;
   logic [4:0]  l15_rqtype;
   logic [2:0]  l15_size;
   logic [39:0] l15_address;
   logic [63:0] l15_data;
   logic        l15_nc;
   logic [3:0]  l15_amo_op;
   logic        l15_threadid, l15_prefetch, l15_inval, l15_bs, l15_bis;
   logic [1:0]  l15_rplway;
   logic [63:0] l15_next_entry;
   logic [32:0] l15_csm;
   logic        header_ack, rsp_val;
   logic [3:0]  rsp_type;
   logic [63:0] rsp_data;
   logic        req_ack;

   int vectors = 0;
   int miscompares = 0;

   tile_core_l15_bridge dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .transducer_l15_val(l15_val), .transducer_l15_rqtype(l15_rqtype),
      .transducer_l15_size(l15_size), .transducer_l15_address(l15_address),
      .transducer_l15_data(l15_data), .transducer_l15_nc(l15_nc),
      .transducer_l15_amo_op(l15_amo_op), .transducer_l15_threadid(l15_threadid),
      .transducer_l15_prefetch(l15_prefetch),
      .transducer_l15_invalidate_cacheline(l15_inval),
      .transducer_l15_blockstore(l15_bs), .transducer_l15_blockinitstore(l15_bis),
      .transducer_l15_l1rplway(l15_rplway),
      .transducer_l15_data_next_entry(l15_next_entry),
      .transducer_l15_csm_data(l15_csm),
      .l15_transducer_header_ack(header_ack), .l15_transducer_val(rsp_val),
      .l15_transducer_returntype(rsp_type), .l15_transducer_data_0(rsp_data),
      .transducer_l15_req_ack(req_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
      tick();
   endtask

   task automatic chk_req(input string tag, input logic [4:0] rq, input logic [2:0] sz,
                          input logic [39:0] a, input logic nc, input logic [63:0] d);
      check({tag, ".val"},  64'(l15_val), 64'd1);
      check({tag, ".rq"},   64'(l15_rqtype), 64'(rq));
      check({tag, ".size"}, 64'(l15_size), 64'(sz));
      check({tag, ".addr"}, 64'(l15_address), 64'(a));
      check({tag, ".nc"},   64'(l15_nc), 64'(nc));
      check({tag, ".data"}, l15_data, d);
   endtask

   task automatic do_ack();
      header_ack = 1'b1;
      tick();
      header_ack = 1'b0;
   endtask

   task automatic respond(input logic [3:0] t, input logic [63:0] d);
      rsp_val = 1'b1; rsp_type = t; rsp_data = d;
      tick();
      rsp_val = 1'b0;
   endtask

   // Store-data expectations as they appear on the L1.5 side.
`ifdef TILE_CORE_L15_BSWAP_EN
   localparam logic [63:0] D_BYTE = 64'h0000_AB00_0000_AB00;
   localparam logic [63:0] D_HALF = 64'h0000_FECA_0000_FECA;
   localparam logic [63:0] D_WORD = 64'h4433_2211_4433_2211;
   localparam logic [31:0] R_LO   = 32'h4444_3333;
   localparam logic [31:0] R_HI   = 32'hBBBB_AAAA;
`else
   localparam logic [63:0] D_BYTE = 64'h00AB_0000_00AB_0000;
   localparam logic [63:0] D_HALF = 64'hCAFE_0000_CAFE_0000;
   localparam logic [63:0] D_WORD = 64'h1122_3344_1122_3344;
   localparam logic [31:0] R_LO   = 32'h3333_4444;
   localparam logic [31:0] R_HI   = 32'hAAAA_BBBB;
`endif

   initial begin
      rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      header_ack = 1'b0; rsp_val = 1'b0; rsp_type = '0; rsp_data = '0;
      tick(); tick();
      check("rst.val",   64'(l15_val), 64'd0);
      check("rst.ready", 64'(mem_ready), 64'd0);
      check("rst.rdata", 64'(mem_rdata), 64'd0);
      check("rst.addr",  64'(l15_address), 64'd0);
      check("rst.rq",    64'(l15_rqtype), 64'd0);
      rst = 1'b0;
      tick();

      // Word load at 0x1004: low half of data_0 returned.
      start_req(32'h0000_1004, 32'h0, 4'b0000);
      chk_req("ld", 5'd0, 3'd2, 40'h00_0000_1004, 1'b0, 64'h0);
      check("ld.next_entry", l15_next_entry, 64'h0);
      check("ld.misc0", 64'({l15_csm, l15_amo_op, l15_threadid, l15_prefetch,
                             l15_inval, l15_bs, l15_bis, l15_rplway}), 64'h0);
      do_ack();
      check("ld.val_drop", 64'(l15_val), 64'd0);
      rsp_val = 1'b1; rsp_type = 4'b0000; rsp_data = 64'h1111_2222_3333_4444;
      #1;
      check("ld.req_ack", 64'(req_ack), 64'd1);
      check("ld.ready_early", 64'(mem_ready), 64'd0);
      tick();
      rsp_val = 1'b0; mem_valid = 1'b0;
      check("ld.ready", 64'(mem_ready), 64'd1);
      check("ld.rdata", 64'(mem_rdata), 64'(R_LO));
      tick();
      check("ld.ready_one", 64'(mem_ready), 64'd0);
      check("ld.rdata_hold", 64'(mem_rdata), 64'(R_LO));

      // Byte store, non-cacheable, header_ack withheld five cycles,
      // invalidation arriving in WAIT before the ST_ACK.
      start_req(32'h8000_0010, 32'h00AB_0000, 4'b0100);
      chk_req("stb", 5'd1, 3'd0, 40'h00_8000_0012, 1'b1, D_BYTE);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_req("stb.hold", 5'd1, 3'd0, 40'h00_8000_0012, 1'b1, D_BYTE);
      end
      do_ack();
      check("stb.val_drop", 64'(l15_val), 64'd0);
      rsp_val = 1'b1; rsp_type = 4'b0011; rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      check("stb.inv_ack", 64'(req_ack), 64'd1);
      tick();
      rsp_val = 1'b0;
      check("stb.inv_noready", 64'(mem_ready), 64'd0);
      respond(4'b0100, 64'h0);
      mem_valid = 1'b0;
      check("stb.ready", 64'(mem_ready), 64'd1);
      check("stb.rdata", 64'(mem_rdata), 64'd0);
      tick();

      // Upper halfword store; response coinciding with header_ack is dropped.
      start_req(32'h0000_3000, 32'hCAFE_0000, 4'b1100);
      chk_req("sth", 5'd1, 3'd1, 40'h00_0000_3002, 1'b0, D_HALF);
      header_ack = 1'b1; rsp_val = 1'b1; rsp_type = 4'b0100;
      #1;
      check("sth.coinc_ack", 64'(req_ack), 64'd1);
      tick();
      header_ack = 1'b0; rsp_val = 1'b0;
      check("sth.val_drop", 64'(l15_val), 64'd0);
      check("sth.no_ready", 64'(mem_ready), 64'd0);
      tick();
      check("sth.still_wait", 64'(mem_ready), 64'd0);
      respond(4'b0000, 64'h1234_5678_9ABC_DEF0);   // type not matched to request
      mem_valid = 1'b0;
      check("sth.ready", 64'(mem_ready), 64'd1);
      check("sth.rdata", 64'(mem_rdata), 64'd0);
      tick();

      // Full word, sparse mask, low halfword.
      start_req(32'h0000_0040, 32'h1122_3344, 4'b1111);
      chk_req("stw", 5'd1, 3'd2, 40'h00_0000_0040, 1'b0, D_WORD);
      do_ack(); respond(4'b0100, 64'h0); mem_valid = 1'b0; tick();
      start_req(32'h0000_0053, 32'h0, 4'b0101);
      check("sparse.size", 64'(l15_size), 64'd2);
      check("sparse.addr", 64'(l15_address), 64'h50);
      do_ack(); respond(4'b0100, 64'h0); mem_valid = 1'b0; tick();
      start_req(32'h0000_0061, 32'h0, 4'b0011);
      check("sthl.size", 64'(l15_size), 64'd1);
      check("sthl.addr", 64'(l15_address), 64'h60);
      do_ack(); respond(4'b0100, 64'h0); mem_valid = 1'b0; tick();

      // Load from an 8-byte aligned address picks the upper half.
      start_req(32'h0000_2000, 32'h0, 4'b0000);
      do_ack();
      respond(4'b0000, 64'hAAAA_BBBB_CCCC_DDDD);
      mem_valid = 1'b0;
      check("ldhi.ready", 64'(mem_ready), 64'd1);
      check("ldhi.rdata", 64'(mem_rdata), 64'(R_HI));
      tick();

      // Stray response in IDLE: acked, nothing else moves.
      rsp_val = 1'b1; rsp_type = 4'b0000; rsp_data = 64'h5555_5555_5555_5555;
      #1;
      check("stray.ack", 64'(req_ack), 64'd1);
      tick();
      rsp_val = 1'b0;
      check("stray.ready", 64'(mem_ready), 64'd0);
      check("stray.val", 64'(l15_val), 64'd0);
      check("stray.rdata", 64'(mem_rdata), 64'(R_HI));

      // Reset while in WAIT, then the late load return.
      start_req(32'h0000_3004, 32'h0, 4'b0000);
      do_ack();
      mem_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstw.val", 64'(l15_val), 64'd0);
      check("rstw.ready", 64'(mem_ready), 64'd0);
      check("rstw.rdata", 64'(mem_rdata), 64'd0);
      check("rstw.addr", 64'(l15_address), 64'd0);
      rsp_val = 1'b1; rsp_type = 4'b0000; rsp_data = 64'h9999_8888_7777_6666;
      #1;
      check("rstw.late_ack", 64'(req_ack), 64'd1);
      tick();
      rsp_val = 1'b0;
      check("rstw.no_ready", 64'(mem_ready), 64'd0);
      check("rstw.rdata_keep", 64'(mem_rdata), 64'd0);
      tick();
      check("rstw.no_ready2", 64'(mem_ready), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
